bit_scan: RTL and testbench

Sequential set-bit iterator that sits directly downstream of the bit-counting primitives. Accepts one W-bit word over a valid/ready handshake. Emits the index of every set bit, lowest first, one per cycle, with a remaining-count tag and a last flag. It is the consumer that turns the combinational ctz/popcount results into a stream, for use in allocator and scheduler bitmaps.

---
 rtl/bit_scan_pkg.sv | 19 +
 rtl/bit_scan.sv | 128 ++++++++++++
 tb/tb_bit_scan.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/bit_scan_pkg.sv
// Shared definitions for the set-bit iterator: FSM state encoding and the
// relation between ORDER (log2 of the word width) and the word width W.
package bit_scan_pkg;

  // ST_EMPTY is only reachable when BIT_SCAN_EMPTY_EN is defined.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_EMPTY = 2'd2
  } state_e;

  localparam int ORDER_DEFAULT = 3;

  // Word width derived from its log2.
  function automatic int word_width(input int order);
    return 1 << order;
  endfunction

endpackage

// File: rtl/bit_scan.sv
// bit_scan: accepts one W-bit word over valid/ready and streams the index of
// every set bit, lowest first, one per cycle, with a remaining-count tag and a
// last flag.
//
// Optional feature macro: BIT_SCAN_EMPTY_EN
//   defined   -> an accepted zero word yields one beat flagged by out_empty
//   undefined -> zero words are consumed silently, no out_empty port
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no word held; ready for a new word
// ST_SCAN  | mask_q holds the remaining set bits; presenting the lowest
// ST_EMPTY | presenting the single beat of an accepted zero word
module bit_scan
  import bit_scan_pkg::*;
#(
  parameter int  ORDER = ORDER_DEFAULT,
  localparam int W     = word_width(ORDER)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ORDER-1:0] out_index,
  output logic [ORDER:0]   out_left,
`ifdef BIT_SCAN_EMPTY_EN
  output logic             out_empty,
`endif
  output logic             out_last
);

  state_e           state_q, state_d;
  logic [W-1:0]     mask_q, mask_d;

  logic [ORDER-1:0] ctz_mask;
  logic [ORDER:0]   pop_mask;
  logic [W-1:0]     mask_rest;
  logic             accept;
  logic             beat_done;

  // Lowest set bit and population count of the remaining mask.
  always_comb begin
    ctz_mask = '0;
    pop_mask = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (mask_q[i]) ctz_mask = ORDER'(i);
    end
    for (int i = 0; i < W; i++) begin
      pop_mask = pop_mask + (ORDER + 1)'(mask_q[i]);
    end
  end

  assign mask_rest = mask_q & (mask_q - W'(1));

  // Beat presentation, decoded from state and mask so reset clears it at once.
  always_comb begin
    out_valid = 1'b0;
    out_index = '0;
    out_left  = '0;
    out_last  = 1'b0;
`ifdef BIT_SCAN_EMPTY_EN
    out_empty = 1'b0;
`endif
    case (state_q)
      ST_SCAN: begin
        out_valid = 1'b1;
        out_index = ctz_mask;
        out_left  = pop_mask;
        out_last  = (mask_rest == '0);
      end
`ifdef BIT_SCAN_EMPTY_EN
      ST_EMPTY: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_empty = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // A new word may load on the same edge the previous word's last beat leaves.
  assign beat_done = out_valid & out_ready;
  assign in_ready  = (state_q == ST_IDLE) | (beat_done & out_last);
  assign accept    = in_valid & in_ready;

  // Next-state and next-mask selection.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    if (beat_done) begin
      if (out_last) begin
        state_d = ST_IDLE;
        mask_d  = '0;
      end else begin
        mask_d  = mask_rest;
      end
    end
    if (accept) begin
      if (in_data != '0) begin
        state_d = ST_SCAN;
        mask_d  = in_data;
      end else begin
`ifdef BIT_SCAN_EMPTY_EN
        state_d = ST_EMPTY;
`else
        state_d = ST_IDLE;
`endif
        mask_d  = '0;
      end
    end
  end

  // State and mask registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
    end
  end

endmodule

// File: tb/tb_bit_scan.sv
// Bench for bit_scan: a queue of expected beats is built from each accepted
// word and compared against the DUT every cycle, alongside directed cases with
// literal expectations.
module tb_bit_scan;
  import bit_scan_pkg::*;

  localparam int ORDER = 3;
  localparam int W     = word_width(ORDER);

  logic             clock;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [ORDER-1:0] out_index;
  logic [ORDER:0]   out_left;
  logic             out_last;
`ifdef BIT_SCAN_EMPTY_EN
  logic             out_empty;
`endif

  bit_scan #(.ORDER(ORDER)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_left  (out_left),
`ifdef BIT_SCAN_EMPTY_EN
    .out_empty (out_empty),
`endif
    .out_last  (out_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    int idx;
    int left;
    bit last;
    bit empty;
  } beat_t;

  beat_t exp_q[$];

  // Every beat a word must produce, lowest set bit first.
  function automatic void push_word(input logic [W-1:0] d);
    int total;
    int k;
    beat_t b;
    total = $countones(d);
    k = 0;
    if (d == '0) begin
`ifdef BIT_SCAN_EMPTY_EN
      b.idx = 0; b.left = 0; b.last = 1'b1; b.empty = 1'b1;
      exp_q.push_back(b);
`endif
      return;
    end
    for (int i = 0; i < W; i++) begin
      if (d[i]) begin
        b.idx   = i;
        b.left  = total - k;
        b.last  = (k == total - 1);
        b.empty = 1'b0;
        exp_q.push_back(b);
        k++;
      end
    end
  endfunction

  // The block takes a word when nothing is pending, or when the final pending
  // beat is being taken this cycle.
  function automatic bit model_ready();
    return (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
  endfunction

  // Reference model advances on each clock edge.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      bit rdy;
      rdy = model_ready();
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (in_valid && rdy) push_word(in_data);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    #2;
    if (!reset) begin
      check("m_out_valid", int'(out_valid), int'(exp_q.size() != 0));
      check("m_in_ready", int'(in_ready), int'(model_ready()));
      if (exp_q.size() != 0) begin
        check("m_out_index", int'(out_index), exp_q[0].idx);
        check("m_out_left", int'(out_left), exp_q[0].left);
        check("m_out_last", int'(out_last), int'(exp_q[0].last));
`ifdef BIT_SCAN_EMPTY_EN
        check("m_out_empty", int'(out_empty), int'(exp_q[0].empty));
`endif
      end
    end
  end

  task automatic step(input logic v, input logic [W-1:0] d, input logic r);
    @(negedge clock);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic beat_lit(input string name, input int idx, input int left, input int last);
    #1;
    check({name, "_valid"}, int'(out_valid), 1);
    check({name, "_index"}, int'(out_index), idx);
    check({name, "_left"}, int'(out_left), left);
    check({name, "_last"}, int'(out_last), last);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #2;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_left", int'(out_left), 0);
    check("rst_out_index", int'(out_index), 0);
    check("rst_out_last", int'(out_last), 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // 0x92: indices 1,4,7
    step(1'b1, 8'h92, 1'b1);
    step(1'b0, 8'h00, 1'b1); beat_lit("h92_b0", 1, 3, 0);
    step(1'b0, 8'h00, 1'b1); beat_lit("h92_b1", 4, 2, 0);
    step(1'b0, 8'h00, 1'b1); beat_lit("h92_b2", 7, 1, 1);
    check("h92_ready_on_last", int'(in_ready), 1);
    step(1'b0, 8'h00, 1'b1); #1 check("h92_after_valid", int'(out_valid), 0);

    // all ones: eight beats counting down from 8
    step(1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1);
      beat_lit("hff", i, 8 - i, (i == 7) ? 1 : 0);
    end

    // backpressure on the first beat of 0x92
    step(1'b1, 8'h92, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h55, 1'b0);
      beat_lit("bp_hold", 1, 3, 0);
      check("bp_in_ready", int'(in_ready), 0);
    end
    step(1'b0, 8'h00, 1'b1); beat_lit("bp_b0", 1, 3, 0);
    step(1'b0, 8'h00, 1'b1); beat_lit("bp_b1", 4, 2, 0);
    step(1'b0, 8'h00, 1'b1); beat_lit("bp_b2", 7, 1, 1);

    // back-to-back single-bit words, no bubble
    step(1'b1, 8'h01, 1'b1);
    step(1'b1, 8'h80, 1'b1); beat_lit("b2b_w0", 0, 1, 1);
    check("b2b_ready", int'(in_ready), 1);
    step(1'b0, 8'h00, 1'b1); beat_lit("b2b_w1", 7, 1, 1);
    step(1'b0, 8'h00, 1'b1);

    // zero word
    step(1'b1, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1); #1;
`ifdef BIT_SCAN_EMPTY_EN
    check("zero_valid", int'(out_valid), 1);
    check("zero_empty", int'(out_empty), 1);
    check("zero_left", int'(out_left), 0);
    check("zero_last", int'(out_last), 1);
    step(1'b0, 8'h00, 1'b1); #1;
`endif
    check("zero_no_beat", int'(out_valid), 0);
    check("zero_ready", int'(in_ready), 1);

    // reset in the middle of a scan
    step(1'b1, 8'hFF, 1'b1);
    step(1'b0, 8'h00, 1'b1); beat_lit("rs_b0", 0, 8, 0);
    step(1'b0, 8'h00, 1'b1); beat_lit("rs_b1", 1, 7, 0);
    step(1'b0, 8'h00, 1'b1); beat_lit("rs_b2", 2, 6, 0);
    #2 reset = 1'b1;
    #1;
    check("rs_valid_drop", int'(out_valid), 0);
    check("rs_ready", int'(in_ready), 1);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rs_post_ready", int'(in_ready), 1);
    check("rs_post_valid", int'(out_valid), 0);
    step(1'b1, 8'h10, 1'b1);
    step(1'b0, 8'h00, 1'b1); beat_lit("rs_h10", 4, 1, 1);
    step(1'b0, 8'h00, 1'b1);

    // random traffic checked by the model
    for (int c = 0; c < 400; c++) begin
      logic [W-1:0] d;
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      d = '0;
      else if (sel == 1) d = '1;
      else               d = W'($urandom);
      step(($urandom_range(0, 1) == 1), d, ($urandom_range(0, 9) < 7));
    end
    step(1'b0, 8'h00, 1'b1);
    for (int c = 0; c < 12; c++) step(1'b0, 8'h00, 1'b1);

    #3;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
